watch_set_ctrl: RTL

//  Time-setting sequencer for the HH:MM watch counter chain (h10/h1/m10/m1).
//  Two debounced buttons walk a digit-select FSM and increment the selected digit.
//  The FSM holds the counters in reset while the time is edited, then releases them to run.

---
 rtl/watch_set_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/watch_set_ctrl.sv
// Time-setting sequencer for the HH:MM counter chain: mode button walks digits, inc button edits them.
// Outputs registered, visible one cycle after the button edge; no backpressure, buttons are sampled every cycle.
module watch_set_ctrl #(
  parameter int BLINK_DIV   = 4096,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic [3:0] cur_h10_i,
  input  logic [3:0] cur_h1_i,
  input  logic [3:0] cur_m10_i,
  input  logic [3:0] cur_m1_i,
  output logic [3:0] ival_h10_o,
  output logic [3:0] ival_h1_o,
  output logic [3:0] ival_m10_o,
  output logic [3:0] ival_m1_o,
  output logic       hold_o,
  output logic [3:0] sel_o,
  output logic       blink_o
);

  localparam logic [2:0] RUN     = 3'd0;
  localparam logic [2:0] SET_H10 = 3'd1;
  localparam logic [2:0] SET_H1  = 3'd2;
  localparam logic [2:0] SET_M10 = 3'd3;
  localparam logic [2:0] SET_M1  = 3'd4;

  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYC > 0);

  logic [2:0]    state, state_nxt;
  logic          mode_prev, inc_prev;
  logic          mode_rise, inc_rise_raw, inc_rise, any_rise;
  logic          in_set, timeout;
  logic [3:0]    h10_n, h1_n, m10_n, m1_n;
  logic [3:0]    h1_max;
  logic [3:0]    sel_nxt;
  logic [BW-1:0] blink_cnt;
  logic [TW-1:0] to_cnt;

  always_comb begin
    mode_rise    = btn_mode_i & ~mode_prev;
    inc_rise_raw = btn_inc_i & ~inc_prev;
    // mode takes precedence; a coincident inc edge is dropped
    inc_rise     = inc_rise_raw & ~mode_rise;
    any_rise     = mode_rise | inc_rise_raw;
    in_set       = (state != RUN);
    timeout      = TO_EN && in_set && !any_rise && (to_cnt == TO_LAST);
    h1_max       = (ival_h10_o == 4'd2) ? 4'd3 : 4'd9;

    state_nxt = state;
    h10_n     = ival_h10_o;
    h1_n      = ival_h1_o;
    m10_n     = ival_m10_o;
    m1_n      = ival_m1_o;

    if (mode_rise) begin
      case (state)
        RUN: begin
          state_nxt = SET_H10;
          h10_n     = cur_h10_i;
          h1_n      = cur_h1_i;
          m10_n     = cur_m10_i;
          m1_n      = cur_m1_i;
        end
        SET_H10: state_nxt = SET_H1;
        SET_H1:  state_nxt = SET_M10;
        SET_M10: state_nxt = SET_M1;
        default: state_nxt = RUN;
      endcase
    end else if (timeout) begin
      state_nxt = RUN;
    end else if (inc_rise) begin
      case (state)
        SET_H10: begin
          h10_n = (ival_h10_o >= 4'd2) ? 4'd0 : ival_h10_o + 4'd1;
          // entering the 20s forbids hours-units above 3
          if (h10_n == 4'd2 && ival_h1_o > 4'd3) h1_n = 4'd0;
        end
        SET_H1:  h1_n  = (ival_h1_o >= h1_max) ? 4'd0 : ival_h1_o + 4'd1;
        SET_M10: m10_n = (ival_m10_o >= 4'd5) ? 4'd0 : ival_m10_o + 4'd1;
        SET_M1:  m1_n  = (ival_m1_o >= 4'd9) ? 4'd0 : ival_m1_o + 4'd1;
        default: ;
      endcase
    end

    case (state_nxt)
      SET_H10: sel_nxt = 4'b1000;
      SET_H1:  sel_nxt = 4'b0100;
      SET_M10: sel_nxt = 4'b0010;
      SET_M1:  sel_nxt = 4'b0001;
      default: sel_nxt = 4'b0000;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= RUN;
      mode_prev  <= 1'b0;
      inc_prev   <= 1'b0;
      ival_h10_o <= 4'd0;
      ival_h1_o  <= 4'd0;
      ival_m10_o <= 4'd0;
      ival_m1_o  <= 4'd0;
      hold_o     <= 1'b0;
      sel_o      <= 4'b0000;
      blink_o    <= 1'b0;
      blink_cnt  <= '0;
      to_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      mode_prev  <= btn_mode_i;
      inc_prev   <= btn_inc_i;
      ival_h10_o <= h10_n;
      ival_h1_o  <= h1_n;
      ival_m10_o <= m10_n;
      ival_m1_o  <= m1_n;
      hold_o     <= (state_nxt != RUN);
      sel_o      <= sel_nxt;

      // any edit or digit change shows the digit solid and restarts the blink phase
      if (state_nxt == RUN || any_rise) begin
        blink_cnt <= '0;
        blink_o   <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_o   <= ~blink_o;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (!TO_EN || state_nxt == RUN || any_rise || state_nxt != state) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_LAST) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule
